sram_axi_bridge: RTL and testbench

Converts the CPU core's two SRAM-like request/response ports (instruction and data) into a single AXI3 master with burst length 1, 32-bit data. Sits directly downstream of the core top. It consumes every fetch, load and store the pipeline issues and returns read data and completion pulses. Supports one outstanding read and one outstanding write, with fixed data-over-instruction read priority.

---
 rtl/sram_axi_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI3 master.
// Supports one outstanding read and one outstanding write; data reads take priority over instruction reads.
module sram_axi_bridge (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} wr_state_t;

    rd_state_t   rd_state_reg, rd_state_next;
    wr_state_t   wr_state_reg, wr_state_next;

    logic [31:0] rd_addr_reg;
    logic [1:0]  rd_size_reg;
    logic        rd_src_data_reg;

    logic [31:0] wr_addr_reg;
    logic [31:0] wr_data_reg;
    logic [1:0]  wr_size_reg;
    logic [3:0]  wr_strb_reg;
    logic        aw_done_reg;
    logic        w_done_reg;

    logic        data_free;
    logic        inst_free;
    logic        grant_data_rd;
    logic        grant_inst_rd;
    logic        accept_wr;
    logic        aw_hs;
    logic        w_hs;

    // A port is free when neither FSM holds a transaction on its behalf, which keeps
    // data-port accesses strictly ordered while letting fetches overlap a store.
    assign data_free = !((rd_state_reg != R_IDLE) && rd_src_data_reg) && (wr_state_reg == W_IDLE);
    assign inst_free = !((rd_state_reg != R_IDLE) && !rd_src_data_reg);

    assign grant_data_rd = resetn && (rd_state_reg == R_IDLE) && data_sram_req && !data_sram_wr && data_free;
    assign grant_inst_rd = resetn && (rd_state_reg == R_IDLE) && !grant_data_rd && inst_sram_req && inst_free;
    assign accept_wr     = resetn && (wr_state_reg == W_IDLE) && data_sram_req && data_sram_wr && data_free;

    assign aw_hs = (wr_state_reg == W_BUSY) && !aw_done_reg && awready;
    assign w_hs  = (wr_state_reg == W_BUSY) && !w_done_reg && wready;

    // State registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state_reg <= R_IDLE;
            wr_state_reg <= W_IDLE;
        end else begin
            rd_state_reg <= rd_state_next;
            wr_state_reg <= wr_state_next;
        end
    end

    // Latched request attributes and write handshake flags
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_addr_reg     <= 32'd0;
            rd_size_reg     <= 2'd0;
            rd_src_data_reg <= 1'b0;
            wr_addr_reg     <= 32'd0;
            wr_data_reg     <= 32'd0;
            wr_size_reg     <= 2'd0;
            wr_strb_reg     <= 4'd0;
            aw_done_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
        end else begin
            if (grant_data_rd) begin
                rd_addr_reg     <= data_sram_addr;
                rd_size_reg     <= data_sram_size;
                rd_src_data_reg <= 1'b1;
            end else if (grant_inst_rd) begin
                rd_addr_reg     <= inst_sram_addr;
                rd_size_reg     <= inst_sram_size;
                rd_src_data_reg <= 1'b0;
            end
            if (accept_wr) begin
                wr_addr_reg <= data_sram_addr;
                wr_data_reg <= data_sram_wdata;
                wr_size_reg <= data_sram_size;
                wr_strb_reg <= data_sram_wstrb;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_reg <= 1'b1;
                if (w_hs)  w_done_reg  <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            R_IDLE:  if (grant_data_rd || grant_inst_rd) rd_state_next = R_ADDR;
            R_ADDR:  if (arready) rd_state_next = R_DATA;
            R_DATA:  if (rvalid) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            W_IDLE:  if (accept_wr) wr_state_next = W_BUSY;
            W_BUSY:  if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) wr_state_next = W_RESP;
            W_RESP:  if (bvalid) wr_state_next = W_IDLE;
            default: wr_state_next = W_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        inst_sram_addr_ok = grant_inst_rd;
        data_sram_addr_ok = grant_data_rd || accept_wr;
        inst_sram_data_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (rd_state_reg)
            R_ADDR: arvalid = 1'b1;
            R_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    inst_sram_data_ok = !rd_src_data_reg;
                    data_sram_data_ok = rd_src_data_reg;
                end
            end
            default: ;
        endcase
        case (wr_state_reg)
            W_BUSY: begin
                awvalid = !aw_done_reg;
                wvalid  = !w_done_reg;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) data_sram_data_ok = 1'b1;
            end
            default: ;
        endcase
    end

    assign inst_sram_rdata = rdata;
    assign data_sram_rdata = rdata;

    assign arid    = {3'd0, rd_src_data_reg};
    assign araddr  = rd_addr_reg;
    assign arsize  = {1'b0, rd_size_reg};
    assign arlen   = 4'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = 4'd1;
    assign awaddr  = wr_addr_reg;
    assign awsize  = {1'b0, wr_size_reg};
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid     = 4'd1;
    assign wdata   = wr_data_reg;
    assign wstrb   = wr_strb_reg;
    assign wlast   = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the AXI slave cycle by cycle
// and checks handshakes, routing and completion pulses against hand-computed values.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [3:0]  inst_sram_wstrb;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid, awlen, awcache;
    logic [31:0] awaddr;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        awvalid, awready;
    logic [3:0]  wid, wstrb;
    logic [31:0] wdata;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and leave time for new stimulus to be applied before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [8:0] ctl_vec();
        return {arvalid, rready, awvalid, wvalid, bready,
                inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok};
    endfunction

    initial begin
        resetn = 1'b0;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_addr = 0;
        inst_sram_wstrb = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_addr = 0;
        data_sram_wstrb = 0; data_sram_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        cyc(); cyc();
        settle();
        check("reset_ctl", {23'd0, ctl_vec()}, 32'd0);
        check("const_w", {wlast, wid, awid, arburst, awburst, arlen, awlen},
              {1'b1, 4'd1, 4'd1, 2'b01, 2'b01, 4'd0, 4'd0});
        resetn = 1'b1;

        // Single instruction read
        cyc();
        inst_sram_req = 1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2'd2;
        settle();
        check("t1_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        cyc();
        inst_sram_req = 0; arready = 1;
        settle();
        check("t1_arvalid", {31'd0, arvalid}, 32'd1);
        check("t1_araddr", araddr, 32'h1c000000);
        check("t1_arid", {28'd0, arid}, 32'd0);
        check("t1_arsize", {29'd0, arsize}, 32'd2);
        check("t1_no_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        cyc();
        arready = 0; rvalid = 1; rdata = 32'h12345678;
        settle();
        check("t1_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        check("t1_inst_rdata", inst_sram_rdata, 32'h12345678);
        check("t1_data_data_ok", {31'd0, data_sram_data_ok}, 32'd0);
        cyc();
        rvalid = 0;
        settle();
        check("t1_idle_ctl", {23'd0, ctl_vec()}, 32'd0);
        $display("txn inst read 1c000000 -> %h", 32'h12345678);

        // Simultaneous inst and data reads: data wins
        inst_sram_req = 1; inst_sram_addr = 32'h1c000004;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h00002000; data_sram_size = 2'd2;
        settle();
        check("t2_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        check("t2_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        cyc();
        data_sram_req = 0; arready = 1;
        settle();
        check("t2_arid_data", {28'd0, arid}, 32'd1);
        check("t2_araddr_data", araddr, 32'h00002000);
        check("t2_inst_blocked", {31'd0, inst_sram_addr_ok}, 32'd0);
        cyc();
        arready = 0; rvalid = 1; rdata = 32'hdeadbeef;
        settle();
        check("t2_data_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        check("t2_data_rdata", data_sram_rdata, 32'hdeadbeef);
        check("t2_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        cyc();
        rvalid = 0;
        settle();
        check("t2_inst_now_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        cyc();
        inst_sram_req = 0; arready = 1;
        settle();
        check("t2_arid_inst", {28'd0, arid}, 32'd0);
        check("t2_araddr_inst", araddr, 32'h1c000004);
        cyc();
        arready = 0; rvalid = 1; rdata = 32'hcafef00d;
        settle();
        check("t2_inst_data_ok2", {31'd0, inst_sram_data_ok}, 32'd1);
        cyc();
        rvalid = 0;
        $display("txn data read 00002000 then inst read 1c000004");

        // Halfword store with delayed awready
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00001000;
        data_sram_size = 2'd1; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h0000abcd;
        settle();
        check("t3_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        cyc();
        data_sram_req = 0; data_sram_wr = 0; awready = 0; wready = 1;
        settle();
        check("t3_c1_vld", {29'd0, awvalid, wvalid, bready}, 32'b110);
        check("t3_awaddr", awaddr, 32'h00001000);
        check("t3_awsize", {29'd0, awsize}, 32'd1);
        check("t3_wstrb", {28'd0, wstrb}, 32'b0011);
        check("t3_wdata", wdata, 32'h0000abcd);
        cyc();
        settle();
        check("t3_c2_vld", {29'd0, awvalid, wvalid, bready}, 32'b100);
        cyc();
        awready = 1;
        settle();
        check("t3_c3_vld", {29'd0, awvalid, wvalid, bready}, 32'b100);
        cyc();
        awready = 0; wready = 0;
        settle();
        check("t3_resp_vld", {29'd0, awvalid, wvalid, bready}, 32'b001);
        check("t3_no_ok_yet", {31'd0, data_sram_data_ok}, 32'd0);
        cyc();
        bvalid = 1;
        settle();
        check("t3_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        cyc();
        bvalid = 0;
        settle();
        check("t3_idle_ctl", {23'd0, ctl_vec()}, 32'd0);
        $display("txn store 00001000 wstrb 3 data 0000abcd");

        // Store outstanding, load waits, inst read overlaps
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00003000;
        data_sram_size = 2'd2; data_sram_wstrb = 4'hf; data_sram_wdata = 32'h55aa55aa;
        settle();
        check("t4_st_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        cyc();
        data_sram_wr = 0; inst_sram_req = 1; inst_sram_addr = 32'h1c000008;
        awready = 1; wready = 1;
        settle();
        check("t4_ld_blocked1", {31'd0, data_sram_addr_ok}, 32'd0);
        check("t4_inst_overlap", {31'd0, inst_sram_addr_ok}, 32'd1);
        cyc();
        inst_sram_req = 0; awready = 0; wready = 0; arready = 1;
        settle();
        check("t4_ld_blocked2", {31'd0, data_sram_addr_ok}, 32'd0);
        check("t4_arid_inst", {28'd0, arid}, 32'd0);
        check("t4_bready", {31'd0, bready}, 32'd1);
        cyc();
        arready = 0; rvalid = 1; rdata = 32'h11112222;
        settle();
        check("t4_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        check("t4_ld_blocked3", {31'd0, data_sram_addr_ok}, 32'd0);
        cyc();
        rvalid = 0; bvalid = 1;
        settle();
        check("t4_st_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        check("t4_ld_blocked4", {31'd0, data_sram_addr_ok}, 32'd0);
        cyc();
        bvalid = 0;
        settle();
        check("t4_ld_accept", {31'd0, data_sram_addr_ok}, 32'd1);
        cyc();
        data_sram_req = 0; arready = 1;
        settle();
        check("t4_arid_data", {28'd0, arid}, 32'd1);
        check("t4_araddr_data", araddr, 32'h00003000);
        cyc();
        arready = 0; rvalid = 1; rdata = 32'h33334444;
        settle();
        check("t4_ld_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        check("t4_ld_rdata", data_sram_rdata, 32'h33334444);
        cyc();
        rvalid = 0;
        $display("txn store 00003000, inst read 1c000008, load 00003000");

        // Reset while waiting in R_DATA
        inst_sram_req = 1; inst_sram_addr = 32'h1c00000c;
        settle();
        check("t5_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        cyc();
        inst_sram_req = 0; arready = 1;
        cyc();
        arready = 0; resetn = 0;
        settle();
        check("t5_rready_pre", {31'd0, rready}, 32'd1);
        cyc();
        resetn = 1; rvalid = 1; rdata = 32'h99999999;
        settle();
        check("t5_post_reset_ctl", {23'd0, ctl_vec()}, 32'd0);
        cyc();
        rvalid = 0;
        $display("txn inst read 1c00000c abandoned by reset");

        // Byte load after reset
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h00001003; data_sram_size = 2'd0;
        settle();
        check("t6_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        cyc();
        data_sram_req = 0; arready = 0;
        settle();
        check("t6_arsize", {29'd0, arsize}, 32'd0);
        check("t6_araddr", araddr, 32'h00001003);
        cyc();
        settle();
        check("t6_arvalid_hold", {31'd0, arvalid}, 32'd1);
        check("t6_araddr_hold", araddr, 32'h00001003);
        arready = 1;
        cyc();
        arready = 0; rvalid = 1; rdata = 32'h000000a5;
        settle();
        check("t6_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        check("t6_rdata", data_sram_rdata, 32'h000000a5);
        cyc();
        rvalid = 0;
        $display("txn byte load 00001003 -> %h", 32'h000000a5);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
